// File: rtl/migration_packet_buffer.sv
// Whole-packet store for migration traffic: captures diverted packets, drops any
// packet that cannot fit, and replays committed packets in order once released.
module migration_packet_buffer #(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 256,
    parameter int ADDR_WIDTH       = 10
) (
    input  logic                          axis_aclk,
    input  logic                          axis_resetn,
    input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    input  logic                          release_en,
    output logic                          empty,
    output logic [ADDR_WIDTH:0]           pkt_count,
    output logic [31:0]                   drop_count
);

    localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
    localparam int WORD_W = 1 + AXIS_TUSER_WIDTH + KEEP_W + AXIS_DATA_WIDTH;
    localparam int PTR_W  = ADDR_WIDTH + 1;
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [PTR_W-1:0] FULL_OCC = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    logic [WORD_W-1:0] mem [DEPTH];

    logic              ready_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  wr_commit_q, wr_commit_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  pkt_count_q, pkt_count_d;
    logic [31:0]       drop_count_q, drop_count_d;
    logic              dropping_q, dropping_d;
    logic              in_pkt_q, in_pkt_d;
    state_t            state_q, state_d;
    logic              m_valid_q, m_valid_d;
    logic [WORD_W-1:0] m_word_q;

    logic              accept_s, full_s, drop_beat_s, wr_en_s, commit_s;
    logic              hs_s, avail_s, rd_en_s, pop_s, m_last_s;
    logic [PTR_W-1:0]  occ_s;

    assign m_last_s = m_word_q[WORD_W-1];

    // Ingress: write, overflow drop with rewind, and commit on tlast
    always_comb begin
        accept_s     = s_axis_tvalid & ready_q;
        occ_s        = wr_ptr_q - rd_ptr_q;
        full_s       = (occ_s == FULL_OCC);
        drop_beat_s  = full_s | dropping_q;
        wr_ptr_d     = wr_ptr_q;
        wr_commit_d  = wr_commit_q;
        dropping_d   = dropping_q;
        in_pkt_d     = in_pkt_q;
        drop_count_d = drop_count_q;
        wr_en_s      = 1'b0;
        commit_s     = 1'b0;
        if (accept_s) begin
            in_pkt_d   = ~s_axis_tlast;
            dropping_d = drop_beat_s & ~s_axis_tlast;
            if (drop_beat_s) begin
                wr_ptr_d = wr_commit_q;
            end else begin
                wr_en_s  = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (s_axis_tlast && drop_beat_s) begin
                if (drop_count_q != 32'hFFFF_FFFF) begin
                    drop_count_d = drop_count_q + 32'd1;
                end else begin
                    drop_count_d = drop_count_q;
                end
            end else if (s_axis_tlast) begin
                wr_commit_d = wr_ptr_q + PTR_W'(1);
                commit_s    = 1'b1;
            end else begin
                commit_s    = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Egress FSM; the output register is the RAM read register, so a read
    // is issued only when the current output beat is absent or being taken
    always_comb begin
        hs_s      = m_valid_q & m_axis_tready;
        avail_s   = (rd_ptr_q != wr_commit_q);
        rd_en_s   = 1'b0;
        pop_s     = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                if ((pkt_count_q != '0) && release_en && avail_s) begin
                    rd_en_s = 1'b1;
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (hs_s && m_last_s) begin
                    pop_s   = 1'b1;
                    state_d = IDLE;
                end else if ((!m_valid_q || hs_s) && avail_s) begin
                    rd_en_s = 1'b1;
                end else begin
                    state_d = STREAM;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rd_en_s) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            m_valid_d = 1'b1;
        end else if (hs_s) begin
            rd_ptr_d  = rd_ptr_q;
            m_valid_d = 1'b0;
        end else begin
            rd_ptr_d  = rd_ptr_q;
            m_valid_d = m_valid_q;
        end
        case ({commit_s, pop_s})
            2'b10:   pkt_count_d = pkt_count_q + PTR_W'(1);
            2'b01:   pkt_count_d = pkt_count_q - PTR_W'(1);
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    // Control and counter state
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            ready_q      <= 1'b0;
            wr_ptr_q     <= '0;
            wr_commit_q  <= '0;
            rd_ptr_q     <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= 32'd0;
            dropping_q   <= 1'b0;
            in_pkt_q     <= 1'b0;
            state_q      <= IDLE;
            m_valid_q    <= 1'b0;
        end else begin
            ready_q      <= 1'b1;
            wr_ptr_q     <= wr_ptr_d;
            wr_commit_q  <= wr_commit_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
            dropping_q   <= dropping_d;
            in_pkt_q     <= in_pkt_d;
            state_q      <= state_d;
            m_valid_q    <= m_valid_d;
        end
    end

    // RAM write port
    always_ff @(posedge axis_aclk) begin
        if (wr_en_s) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
        end
    end

    // RAM registered read port, held while the consumer stalls
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            m_word_q <= '0;
        end else if (rd_en_s) begin
            m_word_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
        end
    end

    assign s_axis_tready = ready_q;
    assign m_axis_tvalid = m_valid_q;
    assign {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = m_word_q;
    assign pkt_count     = pkt_count_q;
    assign drop_count    = drop_count_q;
    assign empty         = (pkt_count_q == '0) && !in_pkt_q && (state_q == IDLE) && !m_valid_q;

endmodule

// File: tb/tb_migration_packet_buffer.sv
// Directed bench for migration_packet_buffer with a 16-beat store.
module tb_migration_packet_buffer;

    localparam int DW = 512;
    localparam int UW = 256;
    localparam int AW = 4;

    logic              clk;
    logic              rst_n;
    logic [DW-1:0]     s_tdata;
    logic [DW/8-1:0]   s_tkeep;
    logic [UW-1:0]     s_tuser;
    logic              s_tvalid, s_tready, s_tlast;
    logic [DW-1:0]     m_tdata;
    logic [DW/8-1:0]   m_tkeep;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid, m_tready, m_tlast;
    logic              release_en, empty;
    logic [AW:0]       pkt_count;
    logic [31:0]       drop_count;

    int vec_cnt = 0;
    int err_cnt = 0;
    int got_d[$];
    logic got_l[$];
    logic got_ok[$];
    logic [127:0] lm;

    migration_packet_buffer #(.AXIS_DATA_WIDTH(DW), .AXIS_TUSER_WIDTH(UW), .ADDR_WIDTH(AW)) dut (
        .axis_aclk(clk), .axis_resetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .release_en(release_en), .empty(empty), .pkt_count(pkt_count), .drop_count(drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] mk_data(input int d);
        return {16{d}};
    endfunction
    function automatic logic [DW/8-1:0] mk_keep(input int d);
        return {2{~d}};
    endfunction
    function automatic logic [UW-1:0] mk_user(input int d);
        return {8{d ^ 32'h5a5a5a5a}};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic last);
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = mk_data(d);
        s_tkeep  = mk_keep(d);
        s_tuser  = mk_user(d);
        s_tlast  = last;
    endtask

    task automatic send_pkt(input int base, input int len);
        for (int k = 0; k < len; k++) push(base + k, (k == len - 1));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
    endtask

    // Accept n egress beats within a cycle budget; optional tready pattern
    // with stall-stability checks, optional release_en drop after rel_off beats.
    task automatic collect(input int n, input int budget, input int rel_off, input bit bp);
        int cyc;
        int ph;
        bit hold_chk;
        logic [DW-1:0] held;
        logic held_l;
        logic [6:0] pat;
        pat = 7'b1101001;
        got_d.delete(); got_l.delete(); got_ok.delete();
        cyc = 0; ph = 0; hold_chk = 1'b0; held = '0; held_l = 1'b0;
        while (got_d.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (hold_chk) begin
                check("hold_valid", 64'(m_tvalid), 64'd1);
                check("hold_data", m_tdata[63:0], held[63:0]);
                check("hold_last", 64'(m_tlast), 64'(held_l));
            end
            m_tready = bp ? pat[ph % 7] : 1'b1;
            ph++;
            hold_chk = m_tvalid && !m_tready;
            held     = m_tdata;
            held_l   = m_tlast;
            if (m_tvalid && m_tready) begin
                got_d.push_back(int'(m_tdata[31:0]));
                got_l.push_back(m_tlast);
                got_ok.push_back((m_tdata == mk_data(int'(m_tdata[31:0]))) &&
                                 (m_tkeep == mk_keep(int'(m_tdata[31:0]))) &&
                                 (m_tuser == mk_user(int'(m_tdata[31:0]))));
                if (got_d.size() == rel_off) release_en = 1'b0;
            end
        end
        @(negedge clk);
        m_tready = 1'b0;
    endtask

    task automatic verify(input string tag, input int base, input int n, input logic [127:0] lastmask);
        check({tag, "_count"}, 64'(got_d.size()), 64'(n));
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            check({tag, "_data"}, 64'(got_d[i]), 64'(base + i));
            check({tag, "_side"}, 64'(got_ok[i]), 64'd1);
            check({tag, "_last"}, 64'(got_l[i]), 64'(lastmask[i]));
        end
    endtask

    initial begin
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tkeep = '0; s_tuser = '0;
        m_tready = 1'b0; release_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mvalid", 64'(m_tvalid), 64'd0);
        check("rst_mlast", 64'(m_tlast), 64'd0);
        check("rst_mdata", m_tdata[63:0], 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_sready", 64'(s_tready), 64'd0);
        check("rst_pkt", 64'(pkt_count), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("sready", 64'(s_tready), 64'd1);

        // Basic replay: 1, 4 and 8 beat packets held until release
        send_pkt(0, 1); send_pkt(1, 4); send_pkt(5, 8); idle(3);
        check("basic_pkt", 64'(pkt_count), 64'd3);
        check("basic_gated", 64'(m_tvalid), 64'd0);
        check("basic_notempty", 64'(empty), 64'd0);
        release_en = 1'b1;
        collect(13, 100, -1, 1'b0);
        lm = '0; lm[0] = 1'b1; lm[4] = 1'b1; lm[12] = 1'b1;
        verify("basic", 0, 13, lm);
        idle(3);
        check("basic_empty", 64'(empty), 64'd1);
        check("basic_pkt0", 64'(pkt_count), 64'd0);
        check("basic_drop", 64'(drop_count), 64'd0);

        // Backpressure with tready 1,0,0,1,0,1,1
        send_pkt(100, 4); idle(2);
        collect(4, 60, -1, 1'b1);
        lm = '0; lm[3] = 1'b1;
        verify("bp", 100, 4, lm);
        idle(3);
        check("bp_novalid", 64'(m_tvalid), 64'd0);
        check("bp_empty", 64'(empty), 64'd1);

        // Overflow: 12 beats stored, following 6-beat packet dropped
        release_en = 1'b0;
        send_pkt(200, 12); send_pkt(300, 6); idle(2);
        check("ovf_drop", 64'(drop_count), 64'd1);
        check("ovf_pkt", 64'(pkt_count), 64'd1);
        release_en = 1'b1;
        collect(12, 100, -1, 1'b0);
        lm = '0; lm[11] = 1'b1;
        verify("ovf", 200, 12, lm);
        idle(4);
        check("ovf_novalid", 64'(m_tvalid), 64'd0);
        check("ovf_empty", 64'(empty), 64'd1);

        // Release dropped mid-packet: packet completes, next one waits
        release_en = 1'b0;
        send_pkt(400, 8); send_pkt(500, 2); idle(2);
        release_en = 1'b1;
        collect(8, 100, 2, 1'b0);
        lm = '0; lm[7] = 1'b1;
        verify("gate", 400, 8, lm);
        idle(5);
        check("gate_hold", 64'(m_tvalid), 64'd0);
        check("gate_pkt", 64'(pkt_count), 64'd1);
        release_en = 1'b1;
        collect(2, 50, -1, 1'b0);
        lm = '0; lm[1] = 1'b1;
        verify("gate2", 500, 2, lm);

        // Commit and pop on the same edge leave pkt_count unchanged
        release_en = 1'b0;
        send_pkt(600, 1); idle(2);
        check("same_pkt1", 64'(pkt_count), 64'd1);
        release_en = 1'b1;
        @(negedge clk);
        check("same_valid", 64'(m_tvalid), 64'd1);
        check("same_last", 64'(m_tlast), 64'd1);
        s_tvalid = 1'b1; s_tdata = mk_data(601); s_tkeep = mk_keep(601); s_tuser = mk_user(601); s_tlast = 1'b1;
        m_tready = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
        check("same_pkt", 64'(pkt_count), 64'd1);
        collect(1, 30, -1, 1'b0);
        lm = '0; lm[0] = 1'b1;
        verify("same", 601, 1, lm);
        idle(3);
        check("same_empty", 64'(empty), 64'd1);

        // Wrap-around with ingress and egress running together
        fork
            begin
                for (int p = 0; p < 40; p++) begin
                    send_pkt(1000 + 3 * p, 3);
                    idle(2);
                end
            end
            collect(120, 2000, -1, 1'b0);
        join
        lm = '0;
        for (int i = 0; i < 120; i++) lm[i] = (i % 3 == 2);
        verify("wrap", 1000, 120, lm);
        idle(3);
        check("wrap_drop", 64'(drop_count), 64'd1);
        check("wrap_empty", 64'(empty), 64'd1);
        check("wrap_pkt", 64'(pkt_count), 64'd0);

        // Asynchronous reset mid-ingress and mid-egress
        release_en = 1'b0;
        send_pkt(700, 3); idle(1);
        release_en = 1'b1;
        repeat (2) @(negedge clk);
        check("ar_valid_pre", 64'(m_tvalid), 64'd1);
        push(800, 1'b0);
        @(negedge clk);
        check("ar_empty_pre", 64'(empty), 64'd0);
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(m_tvalid), 64'd0);
        check("ar_pkt", 64'(pkt_count), 64'd0);
        check("ar_empty", 64'(empty), 64'd1);
        s_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("ar_pkt_post", 64'(pkt_count), 64'd0);
        check("ar_empty_post", 64'(empty), 64'd1);
        check("ar_valid_post", 64'(m_tvalid), 64'd0);
        check("ar_drop_post", 64'(drop_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
